// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer for the 8-bit CPU: steps each instruction through
// fetch / execute / memory-or-I/O / write-back and drives the datapath strobes.
module cpu_seq_ctrl #(
    parameter int IO_TIMEOUT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] op,
    input  logic       jp,
    input  logic       io_done,
    output logic       ir_ld,
    output logic       t1,
    output logic       nDRD,
    output logic       nDWR,
    output logic       wbr,
    output logic       wbin,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       busy,
    output logic       io_err,
    output logic [2:0] state_dbg
);

    // Handshake: start is sampled only in IDLE and io_done only in IO; both are
    // level signals, taken on the rising edge they are seen high, never queued.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_EX   = 3'd2,
        S_MA   = 3'd3,
        S_IO   = 3'd4,
        S_WB   = 3'd5,
        S_BR   = 3'd6
    } state_t;

    localparam logic [4:0] OP_JMP = 5'b00000;
    localparam logic [4:0] OP_JZ  = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_ADD = 5'b00110;
    localparam logic [4:0] OP_STA = 5'b01100;
    localparam logic [4:0] OP_LDA = 5'b01110;
    localparam logic [4:0] OP_OUT = 5'b10000;
    localparam logic [4:0] OP_IN  = 5'b10010;
    localparam logic [4:0] OP_HLT = 5'b11111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             io_timeout;

    assign io_timeout = (cnt == CNT_LAST);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            io_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_EX)
                cnt <= '0;
            else if (state == S_IO)
                cnt <= cnt + 1'b1;
            if (state == S_IDLE && start)
                io_err <= 1'b0;
            else if (state == S_IO && !io_done && io_timeout)
                io_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_ld     = 1'b0;
        t1        = 1'b0;
        nDRD      = 1'b1;
        nDWR      = 1'b1;
        wbr       = 1'b0;
        wbin      = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_IF;
            end
            S_IF: begin
                ir_ld     = 1'b1;
                state_nxt = S_EX;
            end
            S_EX: begin
                t1 = 1'b1;
                case (op)
                    OP_ADD, OP_SUB: state_nxt = S_WB;
                    OP_LDA, OP_STA: state_nxt = S_MA;
                    OP_IN,  OP_OUT: state_nxt = S_IO;
                    OP_JZ,  OP_JMP: state_nxt = S_BR;
                    OP_HLT:         state_nxt = S_IDLE;
                    default: begin
                        // MOV, MVI and unlisted opcodes finish in EX
                        pc_inc    = 1'b1;
                        state_nxt = S_IF;
                    end
                endcase
            end
            S_MA: begin
                nDRD      = (op != OP_LDA);
                nDWR      = (op != OP_STA);
                pc_inc    = 1'b1;
                state_nxt = S_IF;
            end
            S_IO: begin
                if (io_done) begin
                    if (op == OP_IN) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_inc    = 1'b1;
                        state_nxt = S_IF;
                    end
                end else if (io_timeout) begin
                    // abandon the transfer and skip the instruction
                    pc_inc    = 1'b1;
                    state_nxt = S_IF;
                end
            end
            S_WB: begin
                wbr       = (op == OP_ADD) || (op == OP_SUB);
                wbin      = (op == OP_IN);
                pc_inc    = 1'b1;
                state_nxt = S_IF;
            end
            S_BR: begin
                pc_ld     = jp;
                pc_inc    = !jp;
                state_nxt = S_IF;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: walks each instruction class cycle by cycle
// and checks strobes against hand-derived expectations.
module tb_cpu_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] op;
    logic       jp;
    logic       io_done;
    logic       ir_ld, t1, nDRD, nDWR, wbr, wbin, pc_inc, pc_ld, busy, io_err;
    logic [2:0] state_dbg;

    int errors;
    int checks;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_IF   = 3'd1;
    localparam logic [2:0] ST_EX   = 3'd2;
    localparam logic [2:0] ST_MA   = 3'd3;
    localparam logic [2:0] ST_IO   = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;
    localparam logic [2:0] ST_BR   = 3'd6;

    cpu_seq_ctrl #(.IO_TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .jp(jp), .io_done(io_done),
        .ir_ld(ir_ld), .t1(t1), .nDRD(nDRD), .nDWR(nDWR), .wbr(wbr), .wbin(wbin),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .busy(busy), .io_err(io_err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then let outputs settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 5'b00000;
        jp      = 1'b0;
        io_done = 1'b0;

        // reset
        step();
        step();
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_nDRD", 32'(nDRD), 1);
        chk("rst_nDWR", 32'(nDWR), 1);
        chk("rst_io_err", 32'(io_err), 0);
        chk("rst_strobes", 32'({ir_ld, t1, wbr, wbin, pc_inc, pc_ld}), 0);
        rst = 1'b0;

        // ADD: IF, EX, WB, IF
        op    = 5'b00110;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("add_if_irld", 32'(ir_ld), 1);
        step();
        chk("add_ex_t1", 32'(t1), 1);
        chk("add_ex_pcinc", 32'(pc_inc), 0);
        step();
        chk("add_wb_wbr", 32'(wbr), 1);
        chk("add_wb_pcinc", 32'(pc_inc), 1);
        chk("add_wb_wbin", 32'(wbin), 0);
        step();
        chk("add_next_irld", 32'(ir_ld), 1);

        // JZ taken, then not taken
        op = 5'b00010;
        step();
        chk("jz_ex_t1", 32'(t1), 1);
        jp = 1'b1;
        step();
        chk("jz1_state", 32'(state_dbg), 32'(ST_BR));
        chk("jz1_pcld", 32'(pc_ld), 1);
        chk("jz1_pcinc", 32'(pc_inc), 0);
        step();
        step();
        jp = 1'b0;
        step();
        chk("jz0_pcld", 32'(pc_ld), 0);
        chk("jz0_pcinc", 32'(pc_inc), 1);
        step();

        // IN with io_done on the 4th IO cycle
        op = 5'b10010;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) io_done = 1'b1;
            #1;
            chk("in_io_state", 32'(state_dbg), 32'(ST_IO));
            chk("in_io_busy", 32'(busy), 1);
            chk("in_io_pcinc", 32'(pc_inc), 0);
        end
        step();
        io_done = 1'b0;
        chk("in_wb_wbin", 32'(wbin), 1);
        chk("in_wb_pcinc", 32'(pc_inc), 1);
        chk("in_wb_wbr", 32'(wbr), 0);
        chk("in_io_err", 32'(io_err), 0);
        step();

        // OUT with no io_done: 15 IO cycles then timeout
        op = 5'b10000;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("out_io_state", 32'(state_dbg), 32'(ST_IO));
            chk("out_io_pcinc", 32'(pc_inc), (i == 15) ? 1 : 0);
            chk("out_io_strb", 32'({nDRD, nDWR}), 32'h3);
        end
        step();
        chk("out_to_state", 32'(state_dbg), 32'(ST_IF));
        chk("out_to_err", 32'(io_err), 1);

        // LDA then STA
        op = 5'b01110;
        step();
        chk("lda_ex_nDRD", 32'(nDRD), 1);
        step();
        chk("lda_ma_nDRD", 32'(nDRD), 0);
        chk("lda_ma_nDWR", 32'(nDWR), 1);
        chk("lda_ma_pcinc", 32'(pc_inc), 1);
        step();
        chk("lda_if_nDRD", 32'(nDRD), 1);
        op = 5'b01100;
        step();
        chk("sta_ex_nDWR", 32'(nDWR), 1);
        step();
        chk("sta_ma_nDWR", 32'(nDWR), 0);
        chk("sta_ma_nDRD", 32'(nDRD), 1);
        step();
        chk("sta_if_nDWR", 32'(nDWR), 1);
        chk("err_sticky", 32'(io_err), 1);

        // MOV finishes in EX with pc_inc
        op = 5'b01010;
        step();
        chk("mov_ex_pcinc", 32'(pc_inc), 1);
        step();
        chk("mov_next_if", 32'(state_dbg), 32'(ST_IF));

        // HLT back to IDLE; io_err held until start
        op = 5'b11111;
        step();
        chk("hlt_ex_pcinc", 32'(pc_inc), 0);
        step();
        chk("hlt_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("hlt_err_held", 32'(io_err), 1);
        start = 1'b1;
        step();
        chk("start_clr_err", 32'(io_err), 0);
        step();
        start = 1'b0;
        chk("start_ignored", 32'(state_dbg), 32'(ST_EX));
        step();
        chk("hlt2_busy", 32'(busy), 0);

        // reset during STA memory access
        op    = 5'b01100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("sta2_ma_nDWR", 32'(nDWR), 0);
        rst = 1'b1;
        step();
        chk("rstma_nDWR", 32'(nDWR), 1);
        chk("rstma_busy", 32'(busy), 0);
        chk("rstma_pcinc", 32'(pc_inc), 0);
        rst = 1'b0;
        step();
        chk("rstma_stay", 32'(state_dbg), 32'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
